hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
- Parametrised successor to the 5-stage RV32I hazard unit: forwarding select, load-use stall, branch flush.
- Adds a multi-cycle MUL/DIV (MDU) stall FSM with a latency counter.
- Adds a data-memory wait-state freeze and a no-forwarding build mode.
- Sits beside the F/D/E/M/W pipeline registers and decodes the instruction words held in D, E, M and W.

Parameters:
- MDU_LAT, 4: cycles an RV32M op (opcode 51, funct7==1) occupies E; must be >=1; 1 means no MDU stall.
- ENABLE_FWD, 1: 1 = forward from M/W; 0 = no forwarding, stall D on any RAW against E/M/W.
- CNT_W, $clog2(MDU_LAT)+1: MDU counter width.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  reset; synchronous, active-high.
- IR_D, IR_E, IR_M, IR_W  input  32 each  instruction words in D/E/M/W.
- pcsrc_E  input  1  taken branch/jump resolved in E.
- regwrite_M, regwrite_W  input  1 each  register write enable in M/W.
- wb_sel_E  input  2  writeback select in E; bit1 = load.
- dmem_ready_M  input  1  data memory ready for the load/store in M.
- stall_F, stall_D, stall_E, stall_M  output  1 each  hold the stage register.
- flush_D, flush_E, flush_M, flush_W  output  1 each  insert a bubble into the stage register.
- forwardA_E, forwardB_E  output  2 each  operand select: 0 = M result, 2 = W result, 1 = register file.
- mdu_busy  output  1  the MDU hold condition is active this cycle.

Behaviour:
- Register addresses:
  - rd_X = IR_X[11:7] unless the opcode is S (35) or B (99), else 0.
  - ra1_X = IR_X[19:15] unless the opcode is U-auipc (23) or J (111), else 0.
  - ra2_X = IR_X[24:20] only for opcodes 35/51/99, else 0.
  - Address 0 never matches.
- Forwarding (ENABLE_FWD=1):
  - Select 0 if ra_E==rd_M && regwrite_M.
  - Else select 2 if ra_E==rd_W && regwrite_W.
  - Else select 1.
  - With ENABLE_FWD=0 the select is constantly 1.
- raw_stall:
  - ENABLE_FWD=1: wb_sel_E[1] && (ra1_D==rd_E || ra2_D==rd_E), with ra!=0.
  - ENABLE_FWD=0: any D source equals a nonzero rd in E, M (with regwrite_M) or W (with regwrite_W).
- mem_stall = IR_M opcode in {3, 35} && !dmem_ready_M.
- MDU FSM, states IDLE and BUSY, counter cnt:
  - IDLE: an MDU op in E with MDU_LAT>1 gives hold=1; next state BUSY, cnt<=MDU_LAT-2.
  - BUSY, cnt!=0: hold=1, cnt<=cnt-1.
  - BUSY, cnt==0: hold=0; next state IDLE only if !mem_stall, otherwise stay in BUSY with cnt held at 0.
  - The counter decrements during mem_stall.
  - Total hold cycles = MDU_LAT-1; the MDU op leaves E on the first non-hold, non-mem_stall cycle.
  - Back-to-back MDU ops re-trigger from IDLE.
- Output priority (highest first):
  1. rst: every stall/flush output = 0, forward selects = 1, mdu_busy = 0. On the next clk edge the state becomes IDLE and cnt = 0, including mid-BUSY.
  2. mem_stall: stall_F/D/E/M = 1, flush_W = 1, all other flushes = 0. pcsrc_E is deferred because the branch is held in E.
  3. hold: stall_F/D/E = 1, flush_M = 1, mdu_busy = 1. raw_stall is not allowed to flush E, because that would kill the MDU op.
  4. pcsrc_E: flush_D = 1, flush_E = 1, no stalls; this overrides raw_stall.
  5. raw_stall: stall_F/D = 1, flush_E = 1.
  6. Otherwise: all stall/flush outputs = 0.
- Forward selects are computed every non-reset cycle regardless of stalls.
- All decode, forwarding and priority logic is combinational. Only the FSM state and cnt are registered.

Test Plan:
- Forwarding: IR_E = add x3,x1,x2; IR_M writes x1 with regwrite_M=1; IR_W writes x2 with regwrite_W=1 -> forwardA_E=0, forwardB_E=2, no stall. Repeat with rd=x0 -> both selects=1.
- Load-use: lw x5 in E (wb_sel_E=2'b10), add x6,x5,x7 in D -> stall_F=stall_D=flush_E=1 for exactly 1 cycle. Same with pcsrc_E=1 -> flush_D=flush_E=1, stall_F=0.
- MDU, MDU_LAT=4: mul enters E at cycle t -> stall_F/D/E=1, flush_M=1, mdu_busy=1 at t..t+2; released at t+3. Back-to-back muls -> 6 hold cycles. MDU_LAT=1 -> 0 hold cycles.
- Mem wait: load in M with dmem_ready_M=0 for 3 cycles while a mul is in BUSY with cnt=1 -> stall_F/D/E/M=1 and flush_W=1 for 3 cycles. The FSM stays BUSY with cnt=0 and returns to IDLE when ready rises.
- Reset mid-BUSY: assert rst in the second hold cycle -> all outputs 0, selects 1 that cycle. After release, state IDLE, cnt=0, no residual stall.
- ENABLE_FWD=0: add x4 in W (regwrite_W=1), sub using x4 in D -> stall_F=stall_D=flush_E=1; forward selects stay 1.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32IM pipeline: forwarding, RAW/load-use stall, branch flush,
// multi-cycle MDU hold and data-memory wait freeze. Only the MDU state and its counter are registered.
module hazard_unit_mc #(
    parameter int MDU_LAT    = 4,
    parameter bit ENABLE_FWD = 1'b1,
    parameter int CNT_W      = $clog2(MDU_LAT) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] IR_M,
    input  logic [31:0] IR_W,
    input  logic        pcsrc_E,
    input  logic        regwrite_M,
    input  logic        regwrite_W,
    input  logic [1:0]  wb_sel_E,
    input  logic        dmem_ready_M,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_D,
    output logic        flush_E,
    output logic        flush_M,
    output logic        flush_W,
    output logic [1:0]  forwardA_E,
    output logic [1:0]  forwardB_E,
    output logic        mdu_busy
);

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_OP     = 7'd51;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;

    localparam bit              MDU_MULTI  = (MDU_LAT > 1);
    localparam int              CNT_INIT_I = (MDU_LAT > 1) ? MDU_LAT - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(CNT_INIT_I);

    typedef enum logic {IDLE, BUSY} mdu_state_t;

    function automatic logic [4:0] rd_of(input logic [31:0] ir);
        return (ir[6:0] == OP_STORE || ir[6:0] == OP_BRANCH) ? 5'd0 : ir[11:7];
    endfunction

    function automatic logic [4:0] ra1_of(input logic [31:0] ir);
        return (ir[6:0] == OP_AUIPC || ir[6:0] == OP_JAL) ? 5'd0 : ir[19:15];
    endfunction

    function automatic logic [4:0] ra2_of(input logic [31:0] ir);
        return (ir[6:0] == OP_STORE || ir[6:0] == OP_OP || ir[6:0] == OP_BRANCH) ? ir[24:20] : 5'd0;
    endfunction

    function automatic logic src_hit(input logic [4:0] ra, input logic [4:0] rd, input logic en);
        return (ra != 5'd0) && (ra == rd) && en;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] ra,
                                           input logic [4:0] rdm, input logic wm,
                                           input logic [4:0] rdw, input logic ww);
        if (src_hit(ra, rdm, wm)) return 2'd0;
        if (src_hit(ra, rdw, ww)) return 2'd2;
        return 2'd1;
    endfunction

    logic [4:0] rd_E, rd_M, rd_W, ra1_D, ra2_D, ra1_E, ra2_E;
    logic       mdu_E, mem_stall, raw_ld, raw_any, raw_stall, hold;
    logic [1:0] fwd_a, fwd_b;
    logic       unused_ok;

    mdu_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign rd_E  = rd_of(IR_E);
    assign rd_M  = rd_of(IR_M);
    assign rd_W  = rd_of(IR_W);
    assign ra1_D = ra1_of(IR_D);
    assign ra2_D = ra2_of(IR_D);
    assign ra1_E = ra1_of(IR_E);
    assign ra2_E = ra2_of(IR_E);

    assign mdu_E     = (IR_E[6:0] == OP_OP) && (IR_E[31:25] == 7'd1);
    assign mem_stall = ((IR_M[6:0] == OP_LOAD) || (IR_M[6:0] == OP_STORE)) && !dmem_ready_M;

    assign raw_ld  = wb_sel_E[1] && (src_hit(ra1_D, rd_E, 1'b1) || src_hit(ra2_D, rd_E, 1'b1));
    // Without forwarding every in-flight producer must retire before D may read it.
    assign raw_any = src_hit(ra1_D, rd_E, 1'b1) || src_hit(ra1_D, rd_M, regwrite_M) ||
                     src_hit(ra1_D, rd_W, regwrite_W) ||
                     src_hit(ra2_D, rd_E, 1'b1) || src_hit(ra2_D, rd_M, regwrite_M) ||
                     src_hit(ra2_D, rd_W, regwrite_W);
    assign raw_stall = ENABLE_FWD ? raw_ld : raw_any;

    assign fwd_a = ENABLE_FWD ? fwd_sel(ra1_E, rd_M, regwrite_M, rd_W, regwrite_W) : 2'd1;
    assign fwd_b = ENABLE_FWD ? fwd_sel(ra2_E, rd_M, regwrite_M, rd_W, regwrite_W) : 2'd1;

    assign unused_ok = ^{IR_D, IR_E, IR_M, IR_W, wb_sel_E};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter keeps running under mem_stall; only the IDLE return waits for memory.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdu_E && MDU_MULTI) begin
                    hold    = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    hold  = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!mem_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        stall_E    = 1'b0;
        stall_M    = 1'b0;
        flush_D    = 1'b0;
        flush_E    = 1'b0;
        flush_M    = 1'b0;
        flush_W    = 1'b0;
        forwardA_E = fwd_a;
        forwardB_E = fwd_b;
        mdu_busy   = 1'b0;
        if (rst) begin
            forwardA_E = 2'd1;
            forwardB_E = 2'd1;
        end else begin
            mdu_busy = hold;
            if (mem_stall) begin
                // Branch in E is frozen with everything else and resolves once memory is ready.
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_W = 1'b1;
            end else if (hold) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                flush_M = 1'b1;
            end else if (pcsrc_E) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (raw_stall) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: three configurations (LAT4/fwd, LAT1/fwd, LAT4/no-fwd) share one stimulus.
module tb_hazard_unit_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir_d, ir_e, ir_m, ir_w;
    logic        pcsrc, rwm, rww, rdy;
    logic [1:0]  wbsel;
    wire  [12:0] v0, v1, v2;
    logic [12:0] e0, e1, e2;
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    // vector layout: {stall_F,D,E,M, flush_D,E,M,W, fwdA, fwdB, mdu_busy}
    localparam logic [12:0] Z     = {4'b0000, 4'b0000, 2'd1, 2'd1, 1'b0};
    localparam logic [12:0] HOLDV = {4'b1110, 4'b0010, 2'd1, 2'd1, 1'b1};
    localparam logic [12:0] RAWV  = {4'b1100, 4'b0100, 2'd1, 2'd1, 1'b0};
    localparam logic [12:0] BRV   = {4'b0000, 4'b1100, 2'd1, 2'd1, 1'b0};
    localparam logic [12:0] MEMV  = {4'b1111, 4'b0001, 2'd1, 2'd1, 1'b0};
    localparam logic [12:0] MEMB  = {4'b1111, 4'b0001, 2'd1, 2'd1, 1'b1};

    always #5 clk = ~clk;

    hazard_unit_mc #(.MDU_LAT(4), .ENABLE_FWD(1'b1)) u0 (
        .clk(clk), .rst(rst), .IR_D(ir_d), .IR_E(ir_e), .IR_M(ir_m), .IR_W(ir_w),
        .pcsrc_E(pcsrc), .regwrite_M(rwm), .regwrite_W(rww), .wb_sel_E(wbsel), .dmem_ready_M(rdy),
        .stall_F(v0[12]), .stall_D(v0[11]), .stall_E(v0[10]), .stall_M(v0[9]),
        .flush_D(v0[8]), .flush_E(v0[7]), .flush_M(v0[6]), .flush_W(v0[5]),
        .forwardA_E(v0[4:3]), .forwardB_E(v0[2:1]), .mdu_busy(v0[0]));

    hazard_unit_mc #(.MDU_LAT(1), .ENABLE_FWD(1'b1)) u1 (
        .clk(clk), .rst(rst), .IR_D(ir_d), .IR_E(ir_e), .IR_M(ir_m), .IR_W(ir_w),
        .pcsrc_E(pcsrc), .regwrite_M(rwm), .regwrite_W(rww), .wb_sel_E(wbsel), .dmem_ready_M(rdy),
        .stall_F(v1[12]), .stall_D(v1[11]), .stall_E(v1[10]), .stall_M(v1[9]),
        .flush_D(v1[8]), .flush_E(v1[7]), .flush_M(v1[6]), .flush_W(v1[5]),
        .forwardA_E(v1[4:3]), .forwardB_E(v1[2:1]), .mdu_busy(v1[0]));

    hazard_unit_mc #(.MDU_LAT(4), .ENABLE_FWD(1'b0)) u2 (
        .clk(clk), .rst(rst), .IR_D(ir_d), .IR_E(ir_e), .IR_M(ir_m), .IR_W(ir_w),
        .pcsrc_E(pcsrc), .regwrite_M(rwm), .regwrite_W(rww), .wb_sel_E(wbsel), .dmem_ready_M(rdy),
        .stall_F(v2[12]), .stall_D(v2[11]), .stall_E(v2[10]), .stall_M(v2[9]),
        .flush_D(v2[8]), .flush_E(v2[7]), .flush_M(v2[6]), .flush_W(v2[5]),
        .forwardA_E(v2[4:3]), .forwardB_E(v2[2:1]), .mdu_busy(v2[0]));

    function automatic logic [31:0] rtype(logic [6:0] f7, logic [2:0] f3, logic [4:0] rs2, logic [4:0] rs1, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'd51};
    endfunction
    function automatic logic [31:0] itype(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, op};
    endfunction
    function automatic logic [31:0] stype(logic [6:0] op, logic [4:0] rs2, logic [4:0] rs1, logic [4:0] imm5);
        return {7'd0, rs2, rs1, 3'b010, imm5, op};
    endfunction
    function automatic logic [31:0] utype(logic [6:0] op, logic [19:0] up, logic [4:0] rd);
        return {up, rd, op};
    endfunction

    function automatic logic [4:0] rd_f(logic [31:0] ir);
        if (ir[6:0] == 7'd35 || ir[6:0] == 7'd99) return 5'd0;
        return ir[11:7];
    endfunction
    function automatic logic [4:0] ra1_f(logic [31:0] ir);
        if (ir[6:0] == 7'd23 || ir[6:0] == 7'd111) return 5'd0;
        return ir[19:15];
    endfunction
    function automatic logic [4:0] ra2_f(logic [31:0] ir);
        if (ir[6:0] == 7'd35 || ir[6:0] == 7'd51 || ir[6:0] == 7'd99) return ir[24:20];
        return 5'd0;
    endfunction
    function automatic logic [1:0] fsel(bit fwd, logic [4:0] ra, logic [4:0] rdm, logic wm, logic [4:0] rdw, logic ww);
        if (!fwd) return 2'd1;
        if (ra != 5'd0 && ra == rdm && wm) return 2'd0;
        if (ra != 5'd0 && ra == rdw && ww) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [4:0] a, b, c;
        logic [2:0] f3;
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        c  = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0: return rtype(($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, f3, b, c, a);
            1: return rtype(7'h01, f3, b, c, a);
            2: return itype(7'd19, a, c, 12'($urandom));
            3: return itype(7'd3, a, c, 12'($urandom));
            4: return stype(7'd35, b, c, 5'($urandom));
            5: return stype(7'd99, b, c, 5'($urandom));
            6: return utype(7'd55, 20'($urandom), a);
            7: return utype(7'd23, 20'($urandom), a);
            8: return utype(7'd111, 20'($urandom), a);
            default: return itype(7'd103, a, c, 12'($urandom));
        endcase
    endfunction

    // Reference: an MDU op occupies E for lat-1 hold cycles, counted by "el" elapsed hold cycles.
    task automatic model(input int lat, input bit fwd, input int el,
                         output logic [12:0] v, output bit hold, output bit mem);
        logic [4:0] srcs [2];
        logic [4:0] prd  [3];
        logic       pen  [3];
        logic [1:0] fa, fb;
        logic [3:0] st, fl;
        bit raw, mdu;
        srcs[0] = ra1_f(ir_d);  srcs[1] = ra2_f(ir_d);
        prd[0] = rd_f(ir_e); prd[1] = rd_f(ir_m); prd[2] = rd_f(ir_w);
        pen[0] = 1'b1;       pen[1] = rwm;        pen[2] = rww;
        fa = fsel(fwd, ra1_f(ir_e), prd[1], rwm, prd[2], rww);
        fb = fsel(fwd, ra2_f(ir_e), prd[1], rwm, prd[2], rww);
        raw = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                if (srcs[i] != 5'd0 && srcs[i] == prd[j] && pen[j] && (!fwd ? 1'b1 : (j == 0 && wbsel[1])))
                    raw = 1'b1;
        mem  = (ir_m[6:0] == 7'd3 || ir_m[6:0] == 7'd35) && !rdy;
        mdu  = (ir_e[6:0] == 7'd51) && (ir_e[31:25] == 7'd1);
        hold = (lat > 1) && mdu && (el < lat - 1);
        st = 4'b0000;
        fl = 4'b0000;
        if (mem) begin st = 4'b1111; fl = 4'b0001; end
        else if (hold) begin st = 4'b1110; fl = 4'b0010; end
        else if (pcsrc) fl = 4'b1100;
        else if (raw) begin st = 4'b1100; fl = 4'b0100; end
        v = rst ? Z : {st, fl, fa, fb, hold};
    endtask

    task automatic idle();
        ir_d = NOP; ir_e = NOP; ir_m = NOP; ir_w = NOP;
        rwm = 1'b0; rww = 1'b0; wbsel = 2'b00; pcsrc = 1'b0; rdy = 1'b1;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        ir_e = rtype(7'h01, 3'd0, 5'd2, 5'd1, 5'd3);
        ir_m = itype(7'd3, 5'd1, 5'd4, 12'd0); rwm = 1'b1; rdy = 1'b0; pcsrc = 1'b1;
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {Z, Z, Z}) begin n_bad++; $display("FAIL reset_active: got %h want %h", {v0, v1, v2}, {Z, Z, Z}); end
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {Z, Z, Z}) begin n_bad++; $display("FAIL reset_release: got %h want %h", {v0, v1, v2}, {Z, Z, Z}); end
        tick();
    endtask

    task automatic test_forwarding();
        do_reset();
        ir_e = rtype(7'h00, 3'd0, 5'd2, 5'd1, 5'd3);
        ir_m = itype(7'd19, 5'd1, 5'd9, 12'd5); rwm = 1'b1;
        ir_w = rtype(7'h00, 3'd0, 5'd6, 5'd7, 5'd2); rww = 1'b1;
        e0 = {8'h00, 2'd0, 2'd2, 1'b0}; e1 = e0; e2 = Z;
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {e0, e1, e2}) begin n_bad++; $display("FAIL fwd_m_w: got %h want %h", {v0, v1, v2}, {e0, e1, e2}); end
        tick();
        ir_m = itype(7'd19, 5'd0, 5'd9, 12'd5);
        ir_w = rtype(7'h00, 3'd0, 5'd6, 5'd7, 5'd0);
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {Z, Z, Z}) begin n_bad++; $display("FAIL fwd_x0: got %h want %h", {v0, v1, v2}, {Z, Z, Z}); end
        tick();
        ir_m = itype(7'd19, 5'd1, 5'd9, 12'd5);
        ir_w = rtype(7'h00, 3'd0, 5'd6, 5'd7, 5'd1);
        e0 = {8'h00, 2'd0, 2'd1, 1'b0}; e1 = e0;
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {e0, e1, Z}) begin n_bad++; $display("FAIL fwd_m_priority: got %h want %h", {v0, v1, v2}, {e0, e1, Z}); end
        tick();
        rwm = 1'b0;
        e0 = {8'h00, 2'd2, 2'd1, 1'b0}; e1 = e0;
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {e0, e1, Z}) begin n_bad++; $display("FAIL fwd_m_disabled: got %h want %h", {v0, v1, v2}, {e0, e1, Z}); end
        tick();
        ir_e = utype(7'd23, {5'd0, 5'd2, 5'd1, 5'd0}, 5'd3);
        rwm = 1'b1; ir_w = rtype(7'h00, 3'd0, 5'd6, 5'd7, 5'd2);
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {Z, Z, Z}) begin n_bad++; $display("FAIL fwd_auipc_nosrc: got %h want %h", {v0, v1, v2}, {Z, Z, Z}); end
        tick();
        ir_e = itype(7'd19, 5'd3, 5'd1, 12'd2);
        e0 = {8'h00, 2'd0, 2'd1, 1'b0}; e1 = e0;
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {e0, e1, Z}) begin n_bad++; $display("FAIL fwd_itype_no_rs2: got %h want %h", {v0, v1, v2}, {e0, e1, Z}); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        ir_e = itype(7'd3, 5'd5, 5'd1, 12'd0); wbsel = 2'b10;
        ir_d = rtype(7'h00, 3'd0, 5'd7, 5'd5, 5'd6);
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {RAWV, RAWV, RAWV}) begin n_bad++; $display("FAIL load_use: got %h want %h", {v0, v1, v2}, {RAWV, RAWV, RAWV}); end
        tick();
        ir_e = NOP; wbsel = 2'b00; ir_m = itype(7'd3, 5'd5, 5'd1, 12'd0); rwm = 1'b1;
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {Z, Z, RAWV}) begin n_bad++; $display("FAIL load_use_once: got %h want %h", {v0, v1, v2}, {Z, Z, RAWV}); end
        tick();
        ir_e = itype(7'd3, 5'd5, 5'd1, 12'd0); wbsel = 2'b10; ir_m = NOP; rwm = 1'b0; pcsrc = 1'b1;
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {BRV, BRV, BRV}) begin n_bad++; $display("FAIL load_use_branch: got %h want %h", {v0, v1, v2}, {BRV, BRV, BRV}); end
        tick();
        pcsrc = 1'b0; ir_d = itype(7'd19, 5'd6, 5'd7, 12'd5);
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {Z, Z, Z}) begin n_bad++; $display("FAIL load_use_itype_rs2: got %h want %h", {v0, v1, v2}, {Z, Z, Z}); end
        tick();
        ir_e = itype(7'd3, 5'd0, 5'd1, 12'd0); ir_d = rtype(7'h00, 3'd0, 5'd0, 5'd0, 5'd6);
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {Z, Z, Z}) begin n_bad++; $display("FAIL load_use_x0: got %h want %h", {v0, v1, v2}, {Z, Z, Z}); end
        tick();
    endtask

    task automatic test_mdu();
        int h0, h1;
        do_reset();
        h0 = 0; h1 = 0;
        for (int k = 0; k < 5; k++) begin
            ir_e = (k < 4) ? rtype(7'h01, 3'd0, 5'd2, 5'd1, 5'd3) : rtype(7'h20, 3'd0, 5'd2, 5'd1, 5'd3);
            e0 = (k < 3) ? HOLDV : Z;
            @(negedge clk);
            h0 += int'(v0[0]); h1 += int'(v1[0]);
            n_cmp++; if ({v0, v1, v2} !== {e0, Z, e0}) begin n_bad++; $display("FAIL mdu_cycle%0d: got %h want %h", k, {v0, v1, v2}, {e0, Z, e0}); end
            tick();
        end
        n_cmp++; if (h0 != 3 || h1 != 0) begin n_bad++; $display("FAIL mdu_hold_count: got %0d/%0d want 3/0", h0, h1); end
    endtask

    task automatic test_back_to_back();
        int h0, h1;
        do_reset();
        h0 = 0; h1 = 0;
        for (int k = 0; k < 9; k++) begin
            ir_e = (k < 8) ? rtype(7'h01, 3'd4, 5'd2, 5'd1, 5'd3) : NOP;
            e0 = (k < 8 && (k % 4) != 3) ? HOLDV : Z;
            @(negedge clk);
            h0 += int'(v0[0]); h1 += int'(v1[0]);
            n_cmp++; if ({v0, v1, v2} !== {e0, Z, e0}) begin n_bad++; $display("FAIL b2b_cycle%0d: got %h want %h", k, {v0, v1, v2}, {e0, Z, e0}); end
            tick();
        end
        n_cmp++; if (h0 != 6 || h1 != 0) begin n_bad++; $display("FAIL b2b_hold_count: got %0d/%0d want 6/0", h0, h1); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            idle();
            ir_e = (k < 9) ? rtype(7'h01, 3'd0, 5'd2, 5'd1, 5'd3) : NOP;
            if (k >= 2 && k <= 4) begin ir_m = itype(7'd3, 5'd9, 5'd1, 12'd0); rdy = 1'b0; end
            if (k == 3) pcsrc = 1'b1;
            if (k == 9) begin ir_m = rtype(7'h00, 3'd0, 5'd2, 5'd1, 5'd9); rdy = 1'b0; end
            case (k)
                0, 1, 6, 7, 8: begin e0 = HOLDV; e1 = Z; end
                2:             begin e0 = MEMB;  e1 = MEMV; end
                3, 4:          begin e0 = MEMV;  e1 = MEMV; end
                default:       begin e0 = Z;     e1 = Z; end
            endcase
            @(negedge clk);
            n_cmp++; if ({v0, v1, v2} !== {e0, e1, e0}) begin n_bad++; $display("FAIL mem_wait_cycle%0d: got %h want %h", k, {v0, v1, v2}, {e0, e1, e0}); end
            tick();
        end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            rst  = (k == 1);
            ir_e = (k == 2 || k == 6) ? NOP : rtype(7'h01, 3'd0, 5'd2, 5'd1, 5'd3);
            e0 = (k == 0 || (k >= 3 && k <= 5)) ? HOLDV : Z;
            @(negedge clk);
            n_cmp++; if ({v0, v1, v2} !== {e0, Z, e0}) begin n_bad++; $display("FAIL rst_busy_cycle%0d: got %h want %h", k, {v0, v1, v2}, {e0, Z, e0}); end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_no_fwd();
        do_reset();
        ir_w = rtype(7'h00, 3'd0, 5'd2, 5'd1, 5'd4); rww = 1'b1;
        ir_d = rtype(7'h20, 3'd0, 5'd6, 5'd4, 5'd5);
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {Z, Z, RAWV}) begin n_bad++; $display("FAIL nofwd_w: got %h want %h", {v0, v1, v2}, {Z, Z, RAWV}); end
        tick();
        rww = 1'b0;
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {Z, Z, Z}) begin n_bad++; $display("FAIL nofwd_w_disabled: got %h want %h", {v0, v1, v2}, {Z, Z, Z}); end
        tick();
        idle();
        ir_e = rtype(7'h00, 3'd0, 5'd2, 5'd1, 5'd3);
        ir_m = itype(7'd19, 5'd1, 5'd9, 12'd0); rwm = 1'b1;
        e0 = {8'h00, 2'd0, 2'd1, 1'b0};
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {e0, e0, Z}) begin n_bad++; $display("FAIL nofwd_sel_const: got %h want %h", {v0, v1, v2}, {e0, e0, Z}); end
        tick();
        idle();
        ir_e = itype(7'd19, 5'd4, 5'd1, 12'd0);
        ir_d = rtype(7'h20, 3'd0, 5'd6, 5'd4, 5'd5);
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {Z, Z, RAWV}) begin n_bad++; $display("FAIL nofwd_e: got %h want %h", {v0, v1, v2}, {Z, Z, RAWV}); end
        tick();
        ir_d = itype(7'd19, 5'd5, 5'd9, 12'd4);
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {Z, Z, Z}) begin n_bad++; $display("FAIL nofwd_itype_rs2: got %h want %h", {v0, v1, v2}, {Z, Z, Z}); end
        tick();
        ir_e = stype(7'd35, 5'd7, 5'd1, 5'd4);
        ir_d = rtype(7'h20, 3'd0, 5'd6, 5'd4, 5'd5);
        @(negedge clk);
        n_cmp++; if ({v0, v1, v2} !== {Z, Z, Z}) begin n_bad++; $display("FAIL nofwd_store_nord: got %h want %h", {v0, v1, v2}, {Z, Z, Z}); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] pd, pe, pm, pw;
        int   el0, el1, el2;
        bit   h0, h1, h2, m0, m1, m2;
        do_reset();
        pd = NOP; pe = NOP; pm = NOP; pw = NOP;
        el0 = 0; el1 = 0; el2 = 0;
        for (int n = 0; n < 600; n++) begin
            rst  = ($urandom_range(0, 99) < 2);
            ir_d = pd; ir_e = pe; ir_m = pm; ir_w = pw;
            rwm  = (rd_f(pm) != 5'd0 || pm[6:0] != 7'd35) && ($urandom_range(0, 9) != 0);
            rww  = ($urandom_range(0, 9) != 0);
            wbsel = (pe[6:0] == 7'd3) ? 2'b10 : 2'($urandom_range(0, 1));
            pcsrc = (pe[6:0] == 7'd99 || pe[6:0] == 7'd111 || pe[6:0] == 7'd103) && ($urandom_range(0, 3) == 0);
            rdy   = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model(4, 1'b1, el0, e0, h0, m0);
            model(1, 1'b1, el1, e1, h1, m1);
            model(4, 1'b0, el2, e2, h2, m2);
            n_cmp++; if ({v0, v1, v2} !== {e0, e1, e2}) begin n_bad++; $display("FAIL random_%0d: got %h want %h", n, {v0, v1, v2}, {e0, e1, e2}); end
            el0 = rst ? 0 : h0 ? el0 + 1 : m0 ? el0 : 0;
            el1 = rst ? 0 : h1 ? el1 + 1 : m1 ? el1 : 0;
            el2 = rst ? 0 : h2 ? el2 + 1 : m2 ? el2 : 0;
            // Advance the pipeline using the reference's own decisions for the LAT4/fwd build.
            if (e0[9]) pw = NOP;
            else if (e0[10]) begin pw = pm; pm = NOP; end
            else if (e0[8]) begin pw = pm; pm = pe; pe = NOP; pd = NOP; end
            else if (e0[11]) begin pw = pm; pm = pe; pe = NOP; end
            else begin pw = pm; pm = pe; pe = pd; pd = rand_ir(); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_back_to_back();
        test_mem_wait();
        test_reset_mid_busy();
        test_no_fwd();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
